// File: rtl/rr_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_cache_arbiter
// Description : N-channel round-robin arbiter between L1-side requesters
//               (icache, dcache/eviction buffer, prefetchers) and a single
//               shared L2 port. One transaction is in flight at a time:
//               IDLE -> BUSY -> RESP -> IDLE. The winning channel's address,
//               write line and operation are registered at grant, so channel
//               inputs may change freely while the L2 access is in progress.
// Config      : ARB_WRITE_PRIO_EN - when defined, pending writers take
//               precedence over readers in IDLE (round-robin among writers,
//               sharing the same pointer). Ports and timing are identical in
//               both builds.
// Ports       : clk, rst (async, active-high)
//               ch_read/ch_write [N_CH]      per-channel requests
//               ch_address [N_CH*ADDR_W]     channel i at [i*ADDR_W +: ADDR_W]
//               ch_wdata   [N_CH*LINE_W]     channel i at [i*LINE_W +: LINE_W]
//               ch_resp    [N_CH]            one-hot completion pulse
//               ch_rdata   [LINE_W]          registered read line (broadcast)
//               mem_read/mem_write           L2 request strobes (registered)
//               mem_address/mem_wdata        L2 address/line, latched at grant
//               mem_rdata/mem_resp           L2 read line and completion
//               grant_id   [IDX_W]           current owner of the L2 port
//               busy                         arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_cache_arbiter #(
    parameter  int N_CH   = 2,
    parameter  int LINE_W = 128,
    parameter  int ADDR_W = 32,
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    input  logic [N_CH*ADDR_W-1:0]   ch_address,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_resp,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Pointer resets to the last channel so channel 0 is scanned first.
    localparam logic [IDX_W-1:0] c_PTR_RST = IDX_W'(N_CH - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state_q,     w_state_d;
    logic [IDX_W-1:0]    r_ptr_q,       w_ptr_d;
    logic [IDX_W-1:0]    r_grant_q,     w_grant_d;
    logic [ADDR_W-1:0]   r_addr_q,      w_addr_d;
    logic [LINE_W-1:0]   r_wdata_q,     w_wdata_d;
    logic                r_op_wr_q,     w_op_wr_d;
    logic                r_mem_read_q,  w_mem_read_d;
    logic                r_mem_write_q, w_mem_write_d;
    logic [LINE_W-1:0]   r_rdata_q,     w_rdata_d;
    logic [N_CH-1:0]     r_resp_q,      w_resp_d;

    // ------------------------------------------------------------------
    // Arbitration: round-robin scan starting just after the pointer
    // ------------------------------------------------------------------
    logic [N_CH-1:0]     w_req;
    logic [N_CH-1:0]     w_cand;
    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W:0]      w_sum;
    logic [IDX_W-1:0]    w_idx;

    always_comb begin
        w_req = ch_read | ch_write;
`ifdef ARB_WRITE_PRIO_EN
        // Draining evictions before refills: readers only compete when no
        // channel has a write pending.
        w_cand = (|ch_write) ? ch_write : w_req;
`else
        w_cand = w_req;
`endif
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        // One extra bit on the sum keeps ptr+k representable before the
        // modulo-N_CH correction, which works for non-power-of-two N_CH.
        for (int k = 1; k <= N_CH; k++) begin
            w_sum = {1'b0, r_ptr_q} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_CH)) begin
                w_sum = w_sum - (IDX_W+1)'(N_CH);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner's address, write line and operation
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LINE_W-1:0]   w_sel_wdata;
    logic                w_sel_wr;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_addr  = ch_address[i*ADDR_W +: ADDR_W];
                w_sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
                // Read+write together on one channel resolves to a write.
                w_sel_wr    = ch_write[i];
            end
        end
    end

    // One-hot decode of the current owner for the completion pulse.
    logic [N_CH-1:0]     w_grant_oh;

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_grant_oh[i] = (r_grant_q == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_grant_d     = r_grant_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_op_wr_d     = r_op_wr_q;
        w_mem_read_d  = r_mem_read_q;
        w_mem_write_d = r_mem_write_q;
        w_rdata_d     = r_rdata_q;
        w_resp_d      = '0;

        case (r_state_q)
            ST_IDLE: begin
                // mem_resp is deliberately not looked at here.
                if (w_found) begin
                    w_grant_d     = w_winner;
                    w_ptr_d       = w_winner;
                    w_addr_d      = w_sel_addr;
                    w_wdata_d     = w_sel_wdata;
                    w_op_wr_d     = w_sel_wr;
                    w_mem_read_d  = ~w_sel_wr;
                    w_mem_write_d = w_sel_wr;
                    w_state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Channel inputs are ignored until the L2 completes.
                if (mem_resp) begin
                    if (!r_op_wr_q) begin
                        w_rdata_d = mem_rdata;
                    end
                    w_mem_read_d  = 1'b0;
                    w_mem_write_d = 1'b0;
                    w_resp_d      = w_grant_oh;
                    w_state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // No re-grant here: the served channel is still dropping
                // its request during this cycle.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_mem_read_d  = 1'b0;
                w_mem_write_d = 1'b0;
                w_state_d     = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= c_PTR_RST;
            r_grant_q     <= '0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_op_wr_q     <= 1'b0;
            r_mem_read_q  <= 1'b0;
            r_mem_write_q <= 1'b0;
            r_rdata_q     <= '0;
            r_resp_q      <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_grant_q     <= w_grant_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_op_wr_q     <= w_op_wr_d;
            r_mem_read_q  <= w_mem_read_d;
            r_mem_write_q <= w_mem_write_d;
            r_rdata_q     <= w_rdata_d;
            r_resp_q      <= w_resp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ch_resp     = r_resp_q;
    assign ch_rdata    = r_rdata_q;
    assign mem_read    = r_mem_read_q;
    assign mem_write   = r_mem_write_q;
    assign mem_address = r_addr_q;
    assign mem_wdata   = r_wdata_q;
    assign grant_id    = r_grant_q;
    assign busy        = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rr_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_cache_arbiter
// Description : Directed bench for rr_cache_arbiter. A 2-channel instance is
//               driven from a table of single transactions with hand-computed
//               expectations; a 4-channel instance checks rotation order.
//               Hand-written sequences cover reset mid-transaction and a
//               spurious L2 response while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_cache_arbiter;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 2-channel instance ----------------
    logic [1:0]   rd2, wr2, resp2;
    logic [63:0]  addr2;
    logic [255:0] wdata2;
    logic [127:0] rdata2, mwdata2, mrdata2;
    logic         mrd2, mwr2, mresp2, busy2;
    logic [31:0]  maddr2;
    logic [0:0]   gid2;

    rr_cache_arbiter #(.N_CH(2), .LINE_W(128), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst),
        .ch_read(rd2), .ch_write(wr2), .ch_address(addr2), .ch_wdata(wdata2),
        .ch_resp(resp2), .ch_rdata(rdata2),
        .mem_read(mrd2), .mem_write(mwr2), .mem_address(maddr2), .mem_wdata(mwdata2),
        .mem_rdata(mrdata2), .mem_resp(mresp2),
        .grant_id(gid2), .busy(busy2)
    );

    // ---------------- 4-channel instance ----------------
    logic [3:0]   rd4, wr4, resp4;
    logic [63:0]  addr4;
    logic [127:0] wdata4;
    logic [31:0]  rdata4, mwdata4, mrdata4;
    logic         mrd4, mwr4, mresp4, busy4;
    logic [15:0]  maddr4;
    logic [1:0]   gid4;

    rr_cache_arbiter #(.N_CH(4), .LINE_W(32), .ADDR_W(16)) dut4 (
        .clk(clk), .rst(rst),
        .ch_read(rd4), .ch_write(wr4), .ch_address(addr4), .ch_wdata(wdata4),
        .ch_resp(resp4), .ch_rdata(rdata4),
        .mem_read(mrd4), .mem_write(mwr4), .mem_address(maddr4), .mem_wdata(mwdata4),
        .mem_rdata(mrdata4), .mem_resp(mresp4),
        .grant_id(gid4), .busy(busy4)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // At most one completion bit at any time, on both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            check("resp2_onehot0", 128'($countones(resp2) <= 1), 128'(1));
            check("resp4_onehot0", 128'($countones(resp4) <= 1), 128'(1));
        end
    end

    typedef struct {
        logic [1:0]   rd;
        logic [1:0]   wr;
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [127:0] wd0;
        logic [127:0] wd1;
        logic [127:0] mdata;
        int           lat;
        logic         mid;
        logic [0:0]   g;
        logic         erd;
        logic         ewr;
        logic [31:0]  eaddr;
        logic [127:0] ewd;
        logic [127:0] erdata;
    } vec_t;

    vec_t tbl[7];

    task automatic wait_busy2(input string name);
        for (int c = 0; c < 20 && busy2 !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        check(name, 128'(busy2), 128'(1));
    endtask

    task automatic wait_busy4(input string name);
        for (int c = 0; c < 20 && busy4 !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        check(name, 128'(busy4), 128'(1));
    endtask

    // Runs one transaction on dut2; entered and left at posedge+1 in IDLE.
    task automatic run_txn(input vec_t v);
        int cnt;
        logic [1:0] oh;
        oh     = 2'b01 << v.g;
        rd2    = v.rd;
        wr2    = v.wr;
        addr2  = {v.a1, v.a0};
        wdata2 = {v.wd1, v.wd0};
        wait_busy2("grant_timeout");
        check("grant_id",   128'(gid2),  128'(v.g));
        check("mem_read",   128'(mrd2),  128'(v.erd));
        check("mem_write",  128'(mwr2),  128'(v.ewr));
        check("mem_address",128'(maddr2),128'(v.eaddr));
        check("resp_in_busy",128'(resp2),128'(0));
        if (v.ewr) check("mem_wdata", mwdata2, v.ewd);
        cnt = 1;
        if (v.mid) begin
            addr2 = {2{32'hDEAD_0000}};
            rd2   = 2'b11;
        end
        for (int c = 1; c < v.lat; c++) begin
            @(posedge clk); #1;
            if (mrd2 | mwr2) cnt++;
        end
        mrdata2 = v.mdata;
        mresp2  = 1'b1;
        @(posedge clk); #1;
        mresp2  = 1'b0;
        check("ch_resp",       128'(resp2),      128'(oh));
        check("ch_rdata",      rdata2,           v.erdata);
        check("mem_req_drop",  128'(mrd2 | mwr2),128'(0));
        check("addr_held",     128'(maddr2),     128'(v.eaddr));
        check("req_cycles",    128'(cnt),        128'(v.lat));
        rd2 = 2'b00;
        wr2 = 2'b00;
        @(posedge clk); #1;
        check("resp_cleared", 128'(resp2), 128'(0));
        check("back_idle",    128'(busy2), 128'(0));
    endtask

    initial begin
        // rd, wr, a0, a1, wd0, wd1, mdata, lat, mid, g, erd, ewr, eaddr, ewd, erdata
        tbl[0] = '{2'b10, 2'b00, 32'h0, 32'h0000_1040, 128'h0, 128'h0,
                   {16{8'hA5}}, 4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1040, 128'h0, {16{8'hA5}}};
        tbl[1] = '{2'b11, 2'b00, 32'h2000, 32'h3000, 128'h0, 128'h0,
                   {4{32'h1111_1111}}, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 128'h0, {4{32'h1111_1111}}};
        tbl[2] = '{2'b11, 2'b00, 32'h2000, 32'h3000, 128'h0, 128'h0,
                   {4{32'h3333_3333}}, 2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000, 128'h0, {4{32'h3333_3333}}};
        tbl[3] = '{2'b01, 2'b01, 32'h5000, 32'h0, {4{32'h0F0F_0F0F}}, 128'h0,
                   {4{32'hFFFF_FFFF}}, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5000, {4{32'h0F0F_0F0F}}, {4{32'h3333_3333}}};
        tbl[4] = '{2'b00, 2'b10, 32'h0, 32'h4000, 128'h0, {4{32'hCAFE_BABE}},
                   {4{32'hEEEE_EEEE}}, 3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4000, {4{32'hCAFE_BABE}}, {4{32'h3333_3333}}};
`ifdef ARB_WRITE_PRIO_EN
        tbl[5] = '{2'b01, 2'b10, 32'h6000, 32'h7000, 128'h0, {8{16'h1234}},
                   {4{32'h6666_6666}}, 2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7000, {8{16'h1234}}, {4{32'h3333_3333}}};
`else
        tbl[5] = '{2'b01, 2'b10, 32'h6000, 32'h7000, 128'h0, {8{16'h1234}},
                   {4{32'h6666_6666}}, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6000, 128'h0, {4{32'h6666_6666}}};
`endif
        tbl[6] = '{2'b01, 2'b00, 32'h8000, 32'h0, 128'h0, 128'h0,
                   {4{32'h8888_8888}}, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000, 128'h0, {4{32'h8888_8888}}};

        rst = 1'b0;
        rd2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0; mrdata2 = '0; mresp2 = 1'b0;
        rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; mrdata4 = '0; mresp4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy",    128'(busy2),  128'(0));
        check("rst_mem_read",128'(mrd2),   128'(0));
        check("rst_mem_wr",  128'(mwr2),   128'(0));
        check("rst_resp",    128'(resp2),  128'(0));
        check("rst_grant",   128'(gid2),   128'(0));
        check("rst_addr",    128'(maddr2), 128'(0));
        check("rst_rdata",   rdata2,       128'(0));
        check("rst_busy4",   128'(busy4),  128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        check("idle_after_rst", 128'(busy2), 128'(0));

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Spurious L2 completion while idle is ignored.
        mresp2 = 1'b1;
        @(posedge clk); #1;
        mresp2 = 1'b0;
        check("spurious_resp", 128'(resp2), 128'(0));
        check("spurious_busy", 128'(busy2), 128'(0));
        @(posedge clk); #1;
        check("spurious_resp2", 128'(resp2), 128'(0));

        // Reset in the middle of an access.
        rd2   = 2'b10;
        addr2 = {32'h0000_9000, 32'h0000_A000};
        wait_busy2("rst_mid_grant");
        check("rst_mid_pre_rd", 128'(mrd2), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_mem_read", 128'(mrd2),  128'(0));
        check("rst_mid_busy",     128'(busy2), 128'(0));
        check("rst_mid_resp",     128'(resp2), 128'(0));
        @(negedge clk) rst = 1'b0;
        rd2 = 2'b11;
        @(posedge clk); #1;
        check("post_rst_busy",  128'(busy2),  128'(1));
        check("post_rst_grant", 128'(gid2),   128'(0));
        check("post_rst_addr",  128'(maddr2), 128'(32'h0000_A000));
        mresp2 = 1'b1; mrdata2 = {4{32'h5A5A_5A5A}};
        @(posedge clk); #1;
        mresp2 = 1'b0;
        check("post_rst_resp", 128'(resp2), 128'(2'b01));
        rd2 = 2'b00;
        @(posedge clk); #1;

        // Four channels reading continuously: strict rotation from channel 0.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        rd4   = 4'hF;
        addr4 = {16'h4300, 16'h4200, 16'h4100, 16'h4000};
        for (int t = 0; t < 6; t++) begin
            int e;
            e = t % 4;
            wait_busy4("rr4_grant_timeout");
            check("rr4_grant",  128'(gid4),   128'(e));
            check("rr4_addr",   128'(maddr4), 128'(16'(16'h4000 + e * 256)));
            check("rr4_memrd",  128'(mrd4),   128'(1));
            mresp4  = 1'b1;
            mrdata4 = 32'h1000_0000 + 32'(t);
            @(posedge clk); #1;
            mresp4  = 1'b0;
            check("rr4_resp",  128'(resp4),  128'(4'b0001 << e));
            check("rr4_rdata", 128'(rdata4), 128'(32'h1000_0000 + 32'(t)));
            @(posedge clk); #1;
            check("rr4_idle",  128'(busy4),  128'(0));
        end
        rd4 = 4'h0;
        @(posedge clk); #1;

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
